midi_tx: RTL

MIDI_TX -- requirements
Module: midi_tx

---
 rtl/midi_tx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/midi_tx.sv
// -----------------------------------------------------------------------------
// midi_tx : MIDI note-on / note-off message serializer
//
// Accepts one note event per handshake and serializes it as a standard MIDI
// channel-voice message (status, note, velocity) on a single 8N1 serial line.
// Optionally applies MIDI running status: when the new status byte matches
// the status byte of the previous accepted event, only the two data bytes go out.
//
// Parameters
//   CLK_FREQ       system clock frequency in Hz
//   BAUD_RATE      serial bit rate in Hz (31250 for MIDI)
//   RUNNING_STATUS 1 = omit a repeated status byte, 0 = always send it
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   ev_valid     note event presented
//   ev_ready     block can accept an event this cycle (idle, out of reset)
//   ev_on        1 = note-on, 0 = note-off
//   ev_channel   MIDI channel 0-15
//   ev_note      note number 0-127
//   ev_velocity  velocity 0-127
//   tx           serial output, idle high, registered
//   busy         a message is being serialized
//   msg_done     one-cycle pulse in the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module midi_tx #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD_RATE      = 31_250,
  parameter int RUNNING_STATUS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_on,
  input  logic [3:0] ev_channel,
  input  logic [6:0] ev_note,
  input  logic [6:0] ev_velocity,
  output logic       tx,
  output logic       busy,
  output logic       msg_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [1:0] BYTE_STATUS = 2'd0;
  localparam logic [1:0] BYTE_NOTE   = 2'd1;
  localparam logic [1:0] BYTE_LAST   = 2'd2;
  localparam logic [2:0] BIT_LAST    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Byte of the message selected by the byte index.
  function automatic logic [7:0] select_byte(
    input logic [1:0] idx,
    input logic [7:0] status,
    input logic [6:0] note,
    input logic [6:0] vel
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = status;
      2'd1:    b = {1'b0, note};
      2'd2:    b = {1'b0, vel};
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  // last_status_q doubles as the status byte of the message in flight.
  logic [7:0]       last_status_q, last_status_d;
  logic [6:0]       note_q, note_d;
  logic [6:0]       vel_q, vel_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [7:0]       status_s;
  logic             skip_s;
  logic             accept_s;
  logic             bit_end_s;
  logic [7:0]       next_byte_s;

  assign status_s  = {(ev_on ? 4'h9 : 4'h8), ev_channel};
  assign skip_s    = (RUNNING_STATUS != 0) && (status_s == last_status_q);
  // ready_q is only ever high in IDLE, so inputs are never sampled while busy.
  assign accept_s  = ev_valid && ready_q;
  assign bit_end_s = (cnt_q == CNT_LAST);

  // Next-state, counters, field capture and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    byte_idx_d    = byte_idx_q;
    bit_idx_d     = bit_idx_q;
    last_status_d = last_status_q;
    note_d        = note_q;
    vel_d         = vel_q;
    next_byte_s   = 8'hFF;
    tx_d          = 1'b1;
    busy_d        = 1'b0;
    ready_d       = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = CNT_ZERO;
        bit_idx_d = 3'd0;
        if (accept_s) begin
          state_d       = S_START;
          byte_idx_d    = skip_s ? BYTE_NOTE : BYTE_STATUS;
          last_status_d = status_s;
          note_d        = ev_note;
          vel_d         = ev_velocity;
        end else begin
          state_d    = S_IDLE;
          byte_idx_d = BYTE_STATUS;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          cnt_d     = CNT_ZERO;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (bit_idx_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d = CNT_ZERO;
          if (byte_idx_q == BYTE_LAST) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Outputs are computed from the next state so tx moves on the same edge
    // as the state, giving one cycle from accept to the start bit.
    next_byte_s = select_byte(byte_idx_d, last_status_d, note_d, vel_d);
    case (state_d)
      S_IDLE:  tx_d = 1'b1;
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = next_byte_s[bit_idx_d];
      S_STOP:  tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    // Raised one edge early so the pulse covers the last stop-bit cycle.
    done_d  = (state_d == S_STOP) && (byte_idx_d == BYTE_LAST) && (cnt_d == CNT_LAST);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= CNT_ZERO;
      byte_idx_q    <= 2'd0;
      bit_idx_q     <= 3'd0;
      last_status_q <= 8'h00;
      note_q        <= 7'd0;
      vel_q         <= 7'd0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      byte_idx_q    <= byte_idx_d;
      bit_idx_q     <= bit_idx_d;
      last_status_q <= last_status_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ev_ready = ready_q;
  assign msg_done = done_q;

endmodule
